// File: rtl/frame_builder.sv
`default_nettype none
// ============================================================================
// Module   : frame_builder
// Purpose  : Serialises one device-to-host response frame into the TX FIFO.
// Revision : 1.0
// ============================================================================
module frame_builder #(
    parameter logic [7:0] SOF_DEVICE_TO_HOST = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        build_start,
    input  logic [7:0]  status,
    input  logic [7:0]  cmd,
    input  logic [31:0] addr,
    input  logic [7:0]  data_in [0:63],
    input  logic        tx_fifo_full,
    output logic [7:0]  tx_fifo_data,
    output logic        tx_fifo_wr_en,
    output logic        builder_busy,
    output logic        build_done
);

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_SOF  = 4'd1;
    localparam logic [3:0] ST_STAT = 4'd2;
    localparam logic [3:0] ST_CMD  = 4'd3;
    localparam logic [3:0] ST_A0   = 4'd4;
    localparam logic [3:0] ST_A1   = 4'd5;
    localparam logic [3:0] ST_A2   = 4'd6;
    localparam logic [3:0] ST_A3   = 4'd7;
    localparam logic [3:0] ST_DATA = 4'd8;
    localparam logic [3:0] ST_CRC  = 4'd9;
    localparam logic [3:0] ST_DONE = 4'd10;

    localparam logic [7:0] STATUS_OK = 8'h00;
    localparam logic [7:0] CRC_POLY  = 8'h07;

    logic [3:0]  state;
    logic [3:0]  next_state;

    logic [7:0]  status_reg;
    logic [7:0]  cmd_reg;
    logic [31:0] addr_reg;
    logic [7:0]  data_reg [0:63];
    logic [7:0]  crc_reg;
    logic [5:0]  data_idx;

    logic        accept;
    logic        emit;
    logic        covered;
    logic [4:0]  len_plus1;
    logic [6:0]  data_len;
    logic        data_section;
    logic        last_data;

    // CRC-8, MSB first, no reflection; byte-at-a-time form of the serial LFSR.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    assign accept = (state == ST_IDLE) && build_start;

    // Data length derives from the captured command, never the live inputs.
    assign len_plus1 = {1'b0, cmd_reg[3:0]} + 5'd1;

    always_comb begin
        data_len = 7'd0;
        case (cmd_reg[5:4])
            2'b00:   data_len = {2'b00, len_plus1};
            2'b01:   data_len = {1'b0, len_plus1, 1'b0};
            2'b10:   data_len = {len_plus1, 2'b00};
            default: data_len = 7'd0;
        endcase
    end

    assign data_section = (status_reg == STATUS_OK) && cmd_reg[7] && (cmd_reg[5:4] != 2'b11);
    assign last_data    = ({1'b0, data_idx} == (data_len - 7'd1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: byte states advance only on a write cycle
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (build_start)   next_state = ST_SOF;
            ST_SOF:  if (tx_fifo_wr_en) next_state = ST_STAT;
            ST_STAT: if (tx_fifo_wr_en) next_state = ST_CMD;
            ST_CMD:  if (tx_fifo_wr_en) next_state = data_section ? ST_A0 : ST_CRC;
            ST_A0:   if (tx_fifo_wr_en) next_state = ST_A1;
            ST_A1:   if (tx_fifo_wr_en) next_state = ST_A2;
            ST_A2:   if (tx_fifo_wr_en) next_state = ST_A3;
            ST_A3:   if (tx_fifo_wr_en) next_state = ST_DATA;
            ST_DATA: if (tx_fifo_wr_en && last_data) next_state = ST_CRC;
            ST_CRC:  if (tx_fifo_wr_en) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        emit         = 1'b0;
        covered      = 1'b0;
        tx_fifo_data = 8'h00;
        case (state)
            ST_SOF: begin
                emit         = 1'b1;
                tx_fifo_data = SOF_DEVICE_TO_HOST;
            end
            ST_STAT: begin
                emit         = 1'b1;
                covered      = 1'b1;
                tx_fifo_data = status_reg;
            end
            ST_CMD: begin
                emit         = 1'b1;
                covered      = 1'b1;
                tx_fifo_data = cmd_reg;
            end
            ST_A0: begin
                emit         = 1'b1;
                covered      = 1'b1;
                tx_fifo_data = addr_reg[7:0];
            end
            ST_A1: begin
                emit         = 1'b1;
                covered      = 1'b1;
                tx_fifo_data = addr_reg[15:8];
            end
            ST_A2: begin
                emit         = 1'b1;
                covered      = 1'b1;
                tx_fifo_data = addr_reg[23:16];
            end
            ST_A3: begin
                emit         = 1'b1;
                covered      = 1'b1;
                tx_fifo_data = addr_reg[31:24];
            end
            ST_DATA: begin
                emit         = 1'b1;
                covered      = 1'b1;
                tx_fifo_data = data_reg[data_idx];
            end
            ST_CRC: begin
                emit         = 1'b1;
                tx_fifo_data = crc_reg;
            end
            default: begin
                emit         = 1'b0;
                covered      = 1'b0;
                tx_fifo_data = 8'h00;
            end
        endcase
    end

    // Reset gates the strobe so an abort drops the in-flight byte immediately.
    assign tx_fifo_wr_en = emit && !tx_fifo_full && !rst;
    assign builder_busy  = (state != ST_IDLE);
    assign build_done    = (state == ST_DONE);

    // ------------------------------------------------------------------
    // Descriptor capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            status_reg <= 8'h00;
            cmd_reg    <= 8'h00;
            addr_reg   <= 32'h0;
        end else if (accept) begin
            status_reg <= status;
            cmd_reg    <= cmd;
            addr_reg   <= addr;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_reg <= data_in;
        end
    end

    // ------------------------------------------------------------------
    // CRC accumulator and data index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_reg  <= 8'h00;
            data_idx <= 6'd0;
        end else if (state == ST_IDLE) begin
            crc_reg  <= 8'h00;
            data_idx <= 6'd0;
        end else if (tx_fifo_wr_en) begin
            if (covered) begin
                crc_reg <= crc8_next(crc_reg, tx_fifo_data);
            end
            // The final byte leaves the index in place, so index 63 never wraps.
            if ((state == ST_DATA) && !last_data) begin
                data_idx <= data_idx + 6'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_builder.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_builder
// Purpose  : Scoreboard bench for frame_builder; expected bytes queued per frame.
// Revision : 1.0
// ============================================================================
module tb_frame_builder;

    logic        clk;
    logic        rst;
    logic        build_start;
    logic [7:0]  status;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [7:0]  din [0:63];
    logic        tx_fifo_full;
    logic [7:0]  tx_fifo_data;
    logic        tx_fifo_wr_en;
    logic        builder_busy;
    logic        build_done;

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          done_cnt;
    logic [7:0]  exp_q [$];

    frame_builder #(.SOF_DEVICE_TO_HOST(8'hA5)) dut (
        .clk           (clk),
        .rst           (rst),
        .build_start   (build_start),
        .status        (status),
        .cmd           (cmd),
        .addr          (addr),
        .data_in       (din),
        .tx_fifo_full  (tx_fifo_full),
        .tx_fifo_data  (tx_fifo_data),
        .tx_fifo_wr_en (tx_fifo_wr_en),
        .builder_busy  (builder_busy),
        .build_done    (build_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Bit-serial reference CRC-8 (poly 0x07, MSB first).
    function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        logic       fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[7] ^ b[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    task automatic push_frame(input logic [7:0] st, input logic [7:0] cm,
                              input logic [31:0] ad, output int k);
        logic [7:0] c;
        int         n;
        c = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back(st); c = crc_ref(c, st);
        exp_q.push_back(cm); c = crc_ref(c, cm);
        n = (cm[5:4] == 2'b11) ? 0 : ((int'(cm[3:0]) + 1) << cm[5:4]);
        k = 4;
        if (st == 8'h00 && cm[7] && cm[5:4] != 2'b11) begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back(ad[8*i +: 8]);
                c = crc_ref(c, ad[8*i +: 8]);
            end
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(din[i]);
                c = crc_ref(c, din[i]);
            end
            k = 8 + n;
        end
        exp_q.push_back(c);
    endtask

    task automatic scramble();
        status = 8'($urandom);
        cmd    = 8'($urandom);
        addr   = $urandom;
        for (int i = 0; i < 64; i++) din[i] = 8'($urandom);
    endtask

    // Call at #1 after a posedge with the DUT idle; returns the accept cycle.
    task automatic start_frame(input logic [7:0] st, input logic [7:0] cm,
                               input logic [31:0] ad, output int t);
        status      = st;
        cmd         = cm;
        addr        = ad;
        build_start = 1'b1;
        t           = cyc;
        @(posedge clk); #1;
        build_start = 1'b0;
        scramble();
    endtask

    task automatic wait_cycle(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input string tag, input int t, input int k, input int extra);
        int got;
        int d0;
        int dcyc;
        got  = 0;
        dcyc = 0;
        d0   = done_cnt;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (build_done) begin
                got  = 1;
                dcyc = cyc;
                break;
            end
        end
        check({tag, "_done_seen"}, got, 1);
        if (got == 1) check({tag, "_done_lat"}, dcyc - t, k + 1 + extra);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_q_drained"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Scoreboard: every FIFO write must match the head of the expected queue.
    always @(negedge clk) begin
        if (build_done) done_cnt++;
        if (tx_fifo_wr_en) begin
            check("wr_while_full", tx_fifo_full, 0);
            if (exp_q.size() == 0) check("spurious_wr", 1, 0);
            else                   check("tx_byte", tx_fifo_data, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int k;
        n_tests      = 0;
        n_fail       = 0;
        done_cnt     = 0;
        rst          = 1'b1;
        build_start  = 1'b0;
        tx_fifo_full = 1'b0;
        status       = 8'h00;
        cmd          = 8'h00;
        addr         = 32'h0;
        for (int i = 0; i < 64; i++) din[i] = 8'h00;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_wr_en", tx_fifo_wr_en, 0);
        check("rst_busy",  builder_busy, 0);
        check("rst_done",  build_done, 0);
        check("rst_data",  tx_fifo_data, 8'h00);
        @(posedge clk); #1;

        // Write ack
        exp_q.push_back(8'hA5); exp_q.push_back(8'h00);
        exp_q.push_back(8'h20); exp_q.push_back(8'hE0);
        start_frame(8'h00, 8'h20, 32'hDEADBEEF, t);
        @(negedge clk);
        check("busy_after_accept", builder_busy, 1);
        wait_done("wack", t, 4, 0);

        // Read OK, single zero byte
        for (int i = 0; i < 64; i++) din[i] = 8'h00;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h80);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'hEC);
        start_frame(8'h00, 8'h80, 32'h0, t);
        wait_done("rd_ok", t, 9, 0);

        // Read error: no address or data bytes
        exp_q.push_back(8'hA5); exp_q.push_back(8'h01);
        exp_q.push_back(8'h80); exp_q.push_back(8'h9C);
        start_frame(8'h01, 8'h80, 32'h12345678, t);
        wait_done("rd_err", t, 4, 0);

        // Maximum read, 64 data bytes
        for (int i = 0; i < 64; i++) din[i] = 8'(i);
        push_frame(8'h00, 8'hAF, 32'hCAFE0004, k);
        check("max_len", k, 72);
        start_frame(8'h00, 8'hAF, 32'hCAFE0004, t);
        wait_done("max_rd", t, k, 0);

        // Halfword read, SIZE 11 read and other statuses through the model
        scramble();
        push_frame(8'h00, 8'h93, 32'h00001000, k);
        start_frame(8'h00, 8'h93, 32'h00001000, t);
        wait_done("rd_half", t, k, 0);
        push_frame(8'h00, 8'hB2, 32'h00002000, k);
        start_frame(8'h00, 8'hB2, 32'h00002000, t);
        wait_done("rd_size3", t, k, 0);
        push_frame(8'h42, 8'h85, 32'h00003000, k);
        start_frame(8'h42, 8'h85, 32'h00003000, t);
        wait_done("rd_stat42", t, k, 0);

        // Backpressure: 2 stall cycles at SOF, 3 during DATA
        scramble();
        push_frame(8'h00, 8'h91, 32'hA1B2C3D4, k);
        check("bp_len", k, 12);
        tx_fifo_full = 1'b1;
        start_frame(8'h00, 8'h91, 32'hA1B2C3D4, t);
        wait_cycle(t + 3);
        tx_fifo_full = 1'b0;
        wait_cycle(t + 12);
        tx_fifo_full = 1'b1;
        wait_cycle(t + 15);
        tx_fifo_full = 1'b0;
        wait_done("bp", t, k, 5);

        // Reset during A2 aborts the frame
        exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h80);
        exp_q.push_back(8'h44); exp_q.push_back(8'h33);
        start_frame(8'h00, 8'h80, 32'h11223344, t);
        wait_cycle(t + 6);
        rst = 1'b1;
        @(negedge clk);
        check("abort_wr_en", tx_fifo_wr_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", builder_busy, 0);
        check("abort_q_drained", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check("abort_no_done", build_done, 0);
        @(posedge clk); #1;

        exp_q.push_back(8'hA5); exp_q.push_back(8'h00);
        exp_q.push_back(8'h20); exp_q.push_back(8'hE0);
        start_frame(8'h00, 8'h20, 32'h0, t);
        wait_done("wack2", t, 4, 0);

        // build_start while busy must be ignored
        scramble();
        push_frame(8'h00, 8'h80, 32'h55AA55AA, k);
        start_frame(8'h00, 8'h80, 32'h55AA55AA, t);
        wait_cycle(t + 2);
        status      = 8'h00;
        cmd         = 8'hAF;
        build_start = 1'b1;
        @(posedge clk); #1;
        build_start = 1'b0;
        wait_done("busy_ign", t, k, 0);
        repeat (20) @(negedge clk);
        check("busy_ign_idle", builder_busy, 0);
        check("busy_ign_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
